// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for the EX stage: DIV/DIVU/REM/REMU.
// Holds the pipeline via ex_req.stall_req until the result is final.
package ex_divider_pkg;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } pipe_request_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

endpackage

module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    input  logic            ma_stall,
    output pipe_request_t   ex_req,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state, state_next;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic            neg_q;
    logic            neg_r;
    logic            is_rem;
    logic [XLEN-1:0] result_q;

    // Operand decode in IDLE: sign handling and the two single-cycle cases.
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            accept;

    assign is_signed = ~op[0];
    assign rs1_neg   = is_signed & rs1[XLEN-1];
    assign rs2_neg   = is_signed & rs2[XLEN-1];
    // Negating -2^(XLEN-1) yields the same bit pattern, which is its correct unsigned magnitude.
    assign rs1_mag   = rs1_neg ? -rs1 : rs1;
    assign rs2_mag   = rs2_neg ? -rs2 : rs2;
    assign div_zero  = (rs2 == '0);
    assign overflow  = is_signed & (rs1 == MIN_NEG) & (&rs2);
    assign special   = div_zero | overflow;
    assign accept    = (state == IDLE) && start && !flush;

    always_comb begin
        if (div_zero) begin
            special_result = op[1] ? rs1 : '1;
        end else begin
            special_result = op[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] final_result;

    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign take     = ~diff[XLEN];
    assign rem_step = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step = {quo[XLEN-2:0], take};

    always_comb begin
        if (is_rem) begin
            final_result = neg_r ? -rem_step : rem_step;
        end else begin
            final_result = neg_q ? -quo_step : quo_step;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : BUSY;
            BUSY: if (cnt == LAST) state_next = DONE;
            DONE: if (!ma_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == BUSY) ? cnt + 1'b1 : '0;
        end
    end

    // NOTE: datapath registers carry no reset; control state alone decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            quo    <= rs1_mag;
            rem    <= '0;
            dvs    <= rs2_mag;
            neg_q  <= rs1_neg ^ rs2_neg;
            neg_r  <= rs1_neg;
            is_rem <= op[1];
            if (special) begin
                result_q <= special_result;
            end
        end else if (state == BUSY) begin
            quo <= quo_step;
            rem <= rem_step;
            if (cnt == LAST) begin
                result_q <= final_result;
            end
        end
    end

    assign result_valid     = (state == DONE);
    assign result           = result_q;
    assign ex_req.stall_req = !rst && !flush && (((state == IDLE) && start) || (state == BUSY));
    assign ex_req.flush_req = '0;

endmodule

// File: tb/tb_ex_divider.sv
// Randomized and directed bench for ex_divider against an arithmetic reference model.
module tb_ex_divider;
    import ex_divider_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic          flush;
    logic          ma_stall;
    pipe_request_t ex_req;
    logic [31:0]   result;
    logic          result_valid;

    int total = 0;
    int bad   = 0;

    ex_divider #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs1          (rs1),
        .rs2          (rs2),
        .flush        (flush),
        .ma_stall     (ma_stall),
        .ex_req       (ex_req),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Reference: RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Starts an op and samples each cycle until result_valid; returns stall cycles seen.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        cyc = 0;
        #1;
        while (!result_valid && cyc < 64) begin
            total++;
            if (ex_req.stall_req !== 1'b1 || ex_req.flush_req !== 4'd0) begin
                bad++;
                $display("FAIL busy_stall: cycle %0d stall_req=%b flush_req=%h, want 1/0", cyc, ex_req.stall_req, ex_req.flush_req);
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        total++;
        if (result_valid !== 1'b1) begin
            bad++;
            $display("FAIL timeout: result_valid never rose for op=%0d rs1=%h rs2=%h", o, a, b);
        end
    endtask

    task automatic run_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        issue(o, a, b, cyc);
        total++;
        if (cyc !== ref_latency(o, a, b)) begin
            bad++;
            $display("FAIL latency: op=%0d rs1=%h rs2=%h got %0d stall cycles, want %0d", o, a, b, cyc, ref_latency(o, a, b));
        end
        total++;
        if (result !== exp) begin
            bad++;
            $display("FAIL result: op=%0d rs1=%h rs2=%h got %h, want %h", o, a, b, result, exp);
        end
        total++;
        if (ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL done_stall: stall_req=%b in DONE, want 0", ex_req.stall_req);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (result_valid !== 1'b0 || ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL retire: valid=%b stall_req=%b after DONE, want 0/0", result_valid, ex_req.stall_req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        flush = 1'b0; ma_stall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            total++;
            if (result_valid !== 1'b0 || ex_req !== '0) begin
                bad++;
                $display("FAIL reset: valid=%b ex_req=%h, want 0/0", result_valid, ex_req);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        run_div(OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_div(OP_REMU, 32'd100, 32'd7, 32'd2);
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_div(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_div(OP_REMU, 32'd5, 32'd0, 32'd5);
        run_div(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG);
        run_div(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
        run_div(OP_DIVU, MIN_NEG, 32'hFFFF_FFFF, 32'd0);
        run_div(OP_DIV, MIN_NEG, 32'd1, MIN_NEG);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 20)) ^ (b & 32'h8000_0000);
                default: ;
            endcase
            run_div(o, a, b, ref_div(o, a, b));
        end
    endtask

    task automatic test_flush;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        total++;
        if (ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: stall_req=%b with flush, want 0", ex_req.stall_req);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        total++;
        if (result_valid !== 1'b0 || ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: valid=%b stall_req=%b after flush, want 0/0", result_valid, ex_req.stall_req);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL flush_discard: result_valid rose after flushed op, want never");
        end
        run_div(OP_DIVU, 32'd9, 32'd3, 32'd3);
    endtask

    task automatic test_ma_stall;
        int cyc;
        issue(OP_DIVU, 32'd1000, 32'd7, cyc);
        for (int i = 0; i < 5; i++) begin
            ma_stall = 1'b1;
            #1;
            total++;
            if (result_valid !== 1'b1 || result !== 32'd142 || ex_req.stall_req !== 1'b0) begin
                bad++;
                $display("FAIL ma_stall_hold: cycle %0d valid=%b result=%h stall_req=%b, want 1/0000008e/0", i, result_valid, result, ex_req.stall_req);
            end
            @(negedge clk);
        end
        ma_stall = 1'b0;
        #1;
        total++;
        if (result_valid !== 1'b1 || result !== 32'd142) begin
            bad++;
            $display("FAIL ma_stall_release: valid=%b result=%h when ma_stall falls, want 1/0000008e", result_valid, result);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL ma_stall_idle: valid=%b one cycle after release, want 0", result_valid);
        end
    endtask

    task automatic test_rst_mid_busy;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs1 = 32'd55; rs2 = 32'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall: stall_req=%b during rst, want 0", ex_req.stall_req);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        total++;
        if (result_valid !== 1'b0 || ex_req.stall_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle: valid=%b stall_req=%b after rst, want 0/0", result_valid, ex_req.stall_req);
        end
        run_div(OP_DIVU, 32'd100, 32'd7, 32'd14);
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(OP_REMU, 32'd1234567, 32'd1000, cyc);
        total++;
        if (result !== ref_div(OP_REMU, 32'd1234567, 32'd1000)) begin
            bad++;
            $display("FAIL b2b_first: got %h, want %h", result, ref_div(OP_REMU, 32'd1234567, 32'd1000));
        end
        run_div(OP_DIV, 32'hFFFF_FF00, 32'd16, ref_div(OP_DIV, 32'hFFFF_FF00, 32'd16));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_ma_stall();
        test_rst_mid_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
